// File: rtl/bp_me_pkg.sv
// bp_me_pkg: shared types for the memory-end DMA responder.
//   - bsg_cache DMA packet declaration macro (guarded so the real bsg
//     header wins when it is present in the build).
//   - FSM state enum for bp_me_cache_dma_to_mem.
//   - is_pow2 helper used by parameter sanity checks.

`ifndef DECLARE_BSG_CACHE_DMA_PKT_S
`define DECLARE_BSG_CACHE_DMA_PKT_S(addr_width_mp) \
  typedef struct packed { \
    logic                     write_not_read; \
    logic [addr_width_mp-1:0] addr; \
  } bsg_cache_dma_pkt_s
`endif

package bp_me_pkg;

  typedef enum logic [1:0] {
    e_dma_mem_idle,
    e_dma_mem_wait,
    e_dma_mem_read,
    e_dma_mem_write
  } bp_me_dma_mem_state_e;

  function automatic bit is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

endpackage

// File: rtl/bp_me_dma_mem_ram.sv
// bp_me_dma_mem_ram: 1rw word-addressed RAM, synchronous read.
//   clk_i   clock
//   v_i     access enable
//   w_i     1 = write, 0 = read (when v_i)
//   addr_i  word address
//   data_i  write data
//   data_o  read data, registered; holds its value when no read is issued
// Contents are never reset. Replaceable by a hardened macro provided the
// read output holds between reads.

module bp_me_dma_mem_ram #(
    parameter int unsigned width_p      = 64,
    parameter int unsigned els_p        = 4096,
    parameter int unsigned addr_width_p = $clog2(els_p)
) (
    input  logic                    clk_i,
    input  logic                    v_i,
    input  logic                    w_i,
    input  logic [addr_width_p-1:0] addr_i,
    input  logic [width_p-1:0]      data_i,
    output logic [width_p-1:0]      data_o
);

    logic [width_p-1:0] mem_r [els_p];

    always_ff @(posedge clk_i) begin
        if (v_i) begin
            if (w_i) mem_r[addr_i] <= data_i;
            else     data_o        <= mem_r[addr_i];
        end
    end

endmodule

// File: rtl/bp_me_cache_dma_to_mem.sv
// bp_me_cache_dma_to_mem: memory-side responder for the bsg_cache DMA
// interface. Accepts one packet at a time; writes take block_size_in_words_p
// words serially, reads return them serially after read_latency_p idle cycles.
//   clk_i             clock
//   reset_n_i         synchronous active-low reset
//   dma_pkt_i         {write_not_read, addr}
//   dma_pkt_v_i       packet valid
//   dma_pkt_yumi_o    packet consumed
//   dma_data_i        write word
//   dma_data_v_i      write word valid
//   dma_data_yumi_o   write word consumed
//   dma_data_o        read word
//   dma_data_v_o      read word valid
//   dma_data_ready_i  downstream accepts read word

module bp_me_cache_dma_to_mem
  import bp_me_pkg::*;
#(
  parameter int unsigned paddr_width_p         = 40,
  parameter int unsigned dword_width_p         = 64,
  parameter int unsigned block_size_in_words_p = 8,
  parameter int unsigned mem_els_p             = 4096,
  parameter int unsigned read_latency_p        = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [paddr_width_p:0]   dma_pkt_i,
  input  logic                     dma_pkt_v_i,
  output logic                     dma_pkt_yumi_o,
  input  logic [dword_width_p-1:0] dma_data_i,
  input  logic                     dma_data_v_i,
  output logic                     dma_data_yumi_o,
  output logic [dword_width_p-1:0] dma_data_o,
  output logic                     dma_data_v_o,
  input  logic                     dma_data_ready_i
);

  `DECLARE_BSG_CACHE_DMA_PKT_S(paddr_width_p);

  localparam int unsigned idx_w_lp = $clog2(mem_els_p);
  localparam int unsigned blk_w_lp = $clog2(block_size_in_words_p);
  localparam int unsigned cnt_w_lp = blk_w_lp + 1;
  localparam int unsigned lat_w_lp = (read_latency_p > 1) ? $clog2(read_latency_p) : 1;

  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(block_size_in_words_p);
  localparam logic [cnt_w_lp-1:0] cnt_prev_lp = cnt_w_lp'(block_size_in_words_p - 1);
  localparam logic [lat_w_lp-1:0] lat_last_lp = lat_w_lp'(read_latency_p - 1);

  bsg_cache_dma_pkt_s pkt;
  assign pkt = dma_pkt_i;

  // Only the word-index bits above the block offset are kept: the offset
  // is always zero for the base, and the counter supplies it during a burst.
  logic [idx_w_lp-blk_w_lp-1:0] pkt_blk;
  assign pkt_blk = pkt.addr[3+idx_w_lp-1:3+blk_w_lp];

  logic unused_addr;
  assign unused_addr = ^pkt.addr;

  bp_me_dma_mem_state_e         state_r, state_n;
  logic [idx_w_lp-blk_w_lp-1:0] base_r, base_n;
  logic [cnt_w_lp-1:0]          cnt_r, cnt_n;
  logic [lat_w_lp-1:0]          lat_r, lat_n;
  logic                         out_v_r, out_v_n;

  logic pkt_yumi, data_yumi, rd_v, wr_v, deq;

  always_comb begin
    state_n   = state_r;
    base_n    = base_r;
    cnt_n     = cnt_r;
    lat_n     = lat_r;
    out_v_n   = out_v_r;
    pkt_yumi  = 1'b0;
    data_yumi = 1'b0;
    rd_v      = 1'b0;
    wr_v      = 1'b0;
    deq       = out_v_r & dma_data_ready_i;

    case (state_r)
      e_dma_mem_idle: begin
        pkt_yumi = dma_pkt_v_i;
        if (dma_pkt_v_i) begin
          base_n  = pkt_blk;
          cnt_n   = '0;
          lat_n   = '0;
          out_v_n = 1'b0;
          if (pkt.write_not_read)      state_n = e_dma_mem_write;
          else if (read_latency_p > 0) state_n = e_dma_mem_wait;
          else                         state_n = e_dma_mem_read;
        end
      end

      e_dma_mem_wait: begin
        lat_n = lat_r + 1'b1;
        if (lat_r == lat_last_lp) state_n = e_dma_mem_read;
      end

      e_dma_mem_read: begin
        // Issue into the output register when it is empty or draining,
        // giving one word per cycle under continuous ready.
        rd_v    = (~out_v_r | deq) & (cnt_r != cnt_last_lp);
        out_v_n = rd_v | (out_v_r & ~dma_data_ready_i);
        if (rd_v) cnt_n = cnt_r + 1'b1;
        if (deq && (cnt_r == cnt_last_lp)) state_n = e_dma_mem_idle;
      end

      e_dma_mem_write: begin
        data_yumi = dma_data_v_i;
        wr_v      = dma_data_v_i;
        if (dma_data_v_i) begin
          cnt_n = cnt_r + 1'b1;
          if (cnt_r == cnt_prev_lp) state_n = e_dma_mem_idle;
        end
      end

      default: state_n = e_dma_mem_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= e_dma_mem_idle;
      base_r  <= '0;
      cnt_r   <= '0;
      lat_r   <= '0;
      out_v_r <= 1'b0;
    end else begin
      state_r <= state_n;
      base_r  <= base_n;
      cnt_r   <= cnt_n;
      lat_r   <= lat_n;
      out_v_r <= out_v_n;
    end
  end

  // Handshakes are gated by reset so an in-flight burst stops in the same
  // cycle reset is seen, not one edge later.
  assign dma_pkt_yumi_o  = reset_n_i & pkt_yumi;
  assign dma_data_yumi_o = reset_n_i & data_yumi;
  assign dma_data_v_o    = reset_n_i & out_v_r;

  // Offset bits come from the counter only, so a burst wraps within its block.
  logic [idx_w_lp-1:0] ram_addr;
  assign ram_addr = {base_r, cnt_r[blk_w_lp-1:0]};

  bp_me_dma_mem_ram #(
    .width_p (dword_width_p),
    .els_p   (mem_els_p)
  ) ram (
    .clk_i  (clk_i),
    .v_i    (reset_n_i & (rd_v | wr_v)),
    .w_i    (wr_v),
    .addr_i (ram_addr),
    .data_i (dma_data_i),
    .data_o (dma_data_o)
  );

`ifndef SYNTHESIS
  logic pkt_pend_r;
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) pkt_pend_r <= 1'b0;
    else            pkt_pend_r <= dma_pkt_v_i & ~dma_pkt_yumi_o;

    if (reset_n_i && pkt_pend_r)
      assert (dma_pkt_v_i) else $error("dma_pkt_v_i dropped before yumi");
    assert (is_pow2(mem_els_p) && is_pow2(block_size_in_words_p))
      else $error("mem_els_p and block_size_in_words_p must be powers of two");
  end
`endif

endmodule
